muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle HI/LO unit in the execute stage, alongside the ALU.
- Fed by the same decoded operands as the ALU (in1/in2 after forwarding).
- Handles MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO directly.
- Holds the architectural HI/LO registers. Execute-stage control stalls the pipeline while busy=1; MFHI/MFLO read hi/lo.

Parameters:
MUL_BITS, 1, multiplier bits retired per iteration (legal values 1, 2, 4); multiply iterations = 32/MUL_BITS.

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
in1  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
in2  input  32  rt operand (divisor / multiplier)
start  input  1  request; sampled only when busy=0
flush  input  1  synchronous cancel (exception/branch squash)
busy  output  1  operation in flight; pipeline must stall
done  output  1  one-cycle pulse: hi/lo just updated by MULT/DIV
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- States: IDLE, RUN, FIX.
- Reset (resetn=0, async): state=IDLE, hi=lo=0, busy=0, done=0, iteration counter=0. Applies mid-operation as well; the partial result is discarded.
- Accept: at an edge with state=IDLE, start=1, flush=0.
  - MULT/MULTU/DIV/DIVU: latch |in1|, |in2| (signed ops) or raw values (unsigned ops), plus result signs. Counter=0, go to RUN.
  - MTHI: hi<=in1 at that edge, lo unchanged. MTLO: lo<=in1 at that edge, hi unchanged. Stay IDLE, no busy, no done.
  - Other op codes: no effect.
- RUN:
  - Multiply: shift-add, MUL_BITS per edge, 32/MUL_BITS edges.
  - Divide: restoring radix-2, 32 edges, 1 quotient bit per edge.
  - After the last iteration, go to FIX.
- FIX (one edge):
  - Sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes hi/lo, state=IDLE, done=1 for the following cycle only.
- Latency, with start accepted at edge k:
  - busy=1 after edges k .. k+L-1.
  - hi/lo valid and done=1 after edge k+L, where busy=0.
  - L = 32/MUL_BITS+1 for multiply (33 at default); L = 33 for divide.
- busy is a registered state decode (state!=IDLE). It has no combinational path from start.
- done is 0 in every cycle other than the one after FIX.
- Results: MULT/MULTU give {hi,lo} = 64-bit product. DIV/DIVU give lo=quotient, hi=remainder.
- Divide by zero, signed or unsigned: lo=0xFFFFFFFF, hi=in1 as latched (raw, not absolute).
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of the abs/negate path).
- Start while busy=1: ignored; operands are not re-sampled and the running operation is unaffected.
- Flush: at any edge with flush=1, state<=IDLE, counter cleared, hi/lo unchanged, no done.
  - Flush takes priority over start in the same cycle; nothing is accepted.
  - Flush in FIX suppresses the hi/lo write.
- Back-to-back: a new start is accepted in the cycle done=1 (state=IDLE).

Test Plan:
1. Reset, then MULT in1=0xFFFFFFFF in2=7 -> busy=1 for 33 cycles; done=1 after edge k+33 with hi=0xFFFFFFFF, lo=0xFFFFFFF9; done=0 next cycle.
2. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
3. DIV in1=0xFFFFFFF9(-7) in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0xFFFFFFF0/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF0. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Preload hi=0x11, lo=0x22 via MTHI/MTLO (each visible after one edge, other register untouched). Start DIVU. Pulse start with new operands at cycle 5 -> ignored. Flush at cycle 10 -> busy=0 after that edge, no done, hi=0x11, lo=0x22. Start+flush same cycle -> nothing accepted.
6. resetn low mid-multiply (cycle 20) -> busy=0, done=0, hi=lo=0 immediately, before any edge. After release, a new MULTU 3*4 gives lo=12, hi=0. Also issue a second start in the done cycle -> accepted; busy=1 in the next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO unit sitting beside the ALU in execute.
//   MULT/MULTU : shift-add, MUL_BITS multiplier bits per cycle, {hi,lo} = product
//   DIV/DIVU   : restoring radix-2, one quotient bit per cycle, lo = quotient, hi = remainder
//   MTHI/MTLO  : written straight from in1 in the accepting cycle
//
// Ports:
//   clk, resetn      clock (rising edge), asynchronous active-low reset
//   op[2:0]          000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, else no-op
//   in1, in2         rs / rt operands after forwarding
//   start            request, only looked at while busy=0
//   flush            synchronous cancel; beats start, suppresses a pending hi/lo write
//   busy             operation in flight (registered decode of state != IDLE)
//   done             one-cycle pulse after hi/lo were written by a multiply/divide
//   hi, lo           architectural HI/LO registers
//
// Handshake: a request is taken on any rising edge where state is IDLE, start=1
// and flush=0. busy rises after that edge and stays high until the result edge;
// requests presented while busy=1 are dropped without touching the operands.
// done marks the cycle in which the new hi/lo are first visible; the unit is
// already IDLE in that cycle and can take the next request.
module muldiv_unit #(
  parameter int MUL_BITS = 1  // legal values: 1, 2, 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int         MUL_ITERS = 32 / MUL_BITS;
  localparam logic [5:0] MUL_LAST  = 6'(MUL_ITERS - 1);
  localparam logic [5:0] DIV_LAST  = 6'd31;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;       // mul: {partial product, remaining multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;      // mul: |multiplicand|; div: |divisor|
  logic        is_div;
  logic        neg_res;   // product / quotient must be negated
  logic        neg_rem;   // remainder takes the dividend's sign
  logic        div_zero;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic        sgn;
  logic [31:0] abs_in1, abs_in2;
  assign sgn     = ~op[0];
  assign abs_in1 = (sgn && in1[31]) ? -in1 : in1;
  assign abs_in2 = (sgn && in2[31]) ? -in2 : in2;

  logic last_iter;
  assign last_iter = (cnt == (is_div ? DIV_LAST : MUL_LAST));

  // Multiply step: add multiplicand * low digit into the upper half, then shift
  // the whole register right by one digit. The sum needs MUL_BITS extra bits,
  // which land exactly in the space freed by the consumed multiplier digit.
  logic [32+MUL_BITS-1:0] mul_sum;
  logic [63:0]            mul_step;
  assign mul_sum  = {{MUL_BITS{1'b0}}, acc[63:32]}
                  + ({{MUL_BITS{1'b0}}, opnd} * {32'b0, acc[MUL_BITS-1:0]});
  assign mul_step = {mul_sum, acc[31:MUL_BITS]};

  // Restoring divide step: shift {rem,quo} left, trial-subtract the divisor
  // from the 33-bit shifted remainder, keep the difference if it is >= 0.
  logic [32:0] div_diff;
  logic [63:0] div_step;
  assign div_diff = acc[63:31] - {1'b0, opnd};
  assign div_step = div_diff[32] ? {acc[62:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  // Sign correction applied in FIX. Divide by zero leaves remainder = |in1|,
  // so restoring the dividend's sign yields the raw in1 as required.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? -acc[31:0] : acc[31:0]);
  assign rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !op[2]) state_nxt = RUN;
        RUN:     if (last_iter)       state_nxt = FIX;
        FIX:                          state_nxt = IDLE;
        default:                      state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (op)
                3'b000, 3'b001, 3'b010, 3'b011: begin
                  // Multiply keeps the multiplier in acc and the multiplicand
                  // in opnd; divide keeps the dividend in acc, divisor in opnd.
                  acc      <= {32'b0, op[1] ? abs_in1 : abs_in2};
                  opnd     <= op[1] ? abs_in2 : abs_in1;
                  is_div   <= op[1];
                  neg_res  <= sgn && (in1[31] ^ in2[31]);
                  neg_rem  <= sgn && in1[31];
                  div_zero <= op[1] && (in2 == 32'b0);
                  cnt      <= '0;
                end
                3'b100:  hi <= in1;
                3'b101:  lo <= in1;
                default: ;
              endcase
            end
          end
          RUN: begin
            acc <= is_div ? div_step : mul_step;
            cnt <= cnt + 6'd1;
          end
          FIX: begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
            done <= 1'b1;
            cnt  <= '0;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int MUL_BITS = 1;
  localparam int LAT_MUL  = 32 / MUL_BITS + 1;
  localparam int LAT_DIV  = 33;

  // ---------------- clock / reset ----------------
  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  op     = '0;
  logic [31:0] in1    = '0;
  logic [31:0] in2    = '0;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.MUL_BITS(MUL_BITS)) dut (
    .clk(clk), .resetn(resetn), .op(op), .in1(in1), .in2(in2),
    .start(start), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl_hi   = '0;
  logic [31:0] mdl_lo   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      3'd0: r = sa * sb;
      3'd1: r = ua * ub;
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      default: r = {mdl_hi, mdl_lo};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic [63:0] mon_e;
  int          mon_c;
  always begin
    @(posedge clk);
    #1;
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        chk("result", {hi, lo}, mon_e);
        chk("latency", 64'(cyc), 64'(mon_c));
      end
    end
  end

  // ---------------- driver tasks (called one phase after a rising edge) ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    logic [63:0] r;
    op = o; in1 = a; in2 = b; start = 1'b1;
    #1;
    chk("busy_before_edge", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o <= 3'd3) begin
      chk("busy_after_accept", {63'b0, busy}, 64'd1);
      if (track) begin
        r = ref_model(o, a, b);
        exp_q.push_back(r);
        exp_cyc_q.push_back(cyc + ((o < 3'd2) ? LAT_MUL : LAT_DIV));
        mdl_hi = r[63:32];
        mdl_lo = r[31:0];
      end
    end else begin
      if (o == 3'd4) mdl_hi = a;
      if (o == 3'd5) mdl_lo = a;
      chk("busy_move", {63'b0, busy}, 64'd0);
      chk("hilo_move", {hi, lo}, {mdl_hi, mdl_lo});
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  // Issue and run to completion; returns in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    issue(o, a, b, 1'b1);
    if (o <= 3'd3) begin
      while (busy && n < 300) begin
        n++;
        @(posedge clk);
        #1;
      end
      chk("busy_cycles", 64'(n), 64'((o < 3'd2) ? LAT_MUL : LAT_DIV));
      chk("done_pulse", {63'b0, done}, 64'd1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] prev;

    step(3);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    step(1);

    // Directed products, back-to-back in each done cycle
    run_op(3'd0, 32'hFFFF_FFFF, 32'd7);
    chk("mult_neg1_x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF9);
    step(1);
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    chk("mult_minsq", {hi, lo}, 64'h4000_0000_0000_0000);

    // Directed divides
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2);
    chk("divu_7_2", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE);
    chk("div_7_m2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_op(3'd3, 32'd5, 32'd0);
    chk("divu_by0", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0);
    chk("div_by0", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    step(1);

    // Moves
    run_op(3'd4, 32'h11, 32'd0);
    chk("mthi", {32'b0, hi}, 64'h11);
    run_op(3'd5, 32'h22, 32'd0);
    chk("mtlo", {hi, lo}, 64'h0000_0011_0000_0022);

    // Start while busy is ignored: result still from the original operands
    issue(3'd3, 32'd1000, 32'd7, 1'b1);
    step(4);
    op = 3'd1; in1 = 32'd9; in2 = 32'd9; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_ignore", {63'b0, busy}, 64'd1);
    wait_idle();
    chk("ignored_start_result", {hi, lo}, 64'h0000_0006_0000_008E);
    step(1);
    run_op(3'd4, 32'h11, 32'd0);
    run_op(3'd5, 32'h22, 32'd0);

    // Flush mid-divide
    issue(3'd3, 32'd1000, 32'd7, 1'b0);
    step(8);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_done", {63'b0, done}, 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    step(40);
    chk("flush_hilo_later", {hi, lo}, 64'h0000_0011_0000_0022);

    // Start and flush together: nothing accepted
    op = 3'd3; in1 = 32'd50; in2 = 32'd3; start = 1'b1; flush = 1'b1;
    step(1);
    chk("startflush_busy", {63'b0, busy}, 64'd0);
    op = 3'd4; in1 = 32'h99;
    step(1);
    start = 1'b0; flush = 1'b0;
    chk("startflush_mthi", {hi, lo}, 64'h0000_0011_0000_0022);

    // Flush while in FIX: no write, no done
    issue(3'd0, 32'd123, 32'd456, 1'b0);
    step(LAT_MUL - 1);
    chk("fix_busy", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("fixflush_busy", {63'b0, busy}, 64'd0);
    chk("fixflush_done", {63'b0, done}, 64'd0);
    chk("fixflush_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    step(3);

    // Async reset mid-multiply
    issue(3'd0, 32'd12345, 32'd678, 1'b0);
    step(19);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_busy", {63'b0, busy}, 64'd0);
    chk("areset_done", {63'b0, done}, 64'd0);
    chk("areset_hilo", {hi, lo}, 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    mdl_hi = '0;
    mdl_lo = '0;
    step(1);
    resetn = 1'b1;
    step(1);
    run_op(3'd1, 32'd3, 32'd4);
    chk("multu_3x4", {hi, lo}, 64'd12);
    issue(3'd1, 32'd5, 32'd6, 1'b1);
    wait_idle();
    step(1);

    // Randomized mix against the reference model
    for (int i = 0; i < 40; i++) begin
      o    = 3'($urandom_range(0, 7));
      a    = pick();
      b    = pick();
      prev = {mdl_hi, mdl_lo};
      run_op(o, a, b);
      if (o >= 3'd6) chk("noop_hilo", {hi, lo}, prev);
    end

    wait_idle();
    step(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
